instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Supplies instructions to `ProcessorControlUnit` and owns the program counter. It reads instruction memory through the port-B read interface and holds each 16-bit word in an instruction register. It presents that word to the control unit and advances the PC when the control unit asserts `pcEnabled`. Sits between instruction memory (synchronous BRAM, port B) and the control unit's `instruction` input.

## Interface
- `ADDR_WIDTH`, 16, width of PC and memory address
- `RESET_PC`, 0, PC value loaded on reset

- `clock`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset
- `pcEnabled`  in  1  from control unit; request to advance PC and fetch the next instruction
- `branchMux`  in  1  from control unit; next PC = PC + sign-extended `branchDisp`
- `jumpEnable`  in  1  next PC = `jumpTarget` (register-indirect jump)
- `branchDisp`  in  8  signed displacement ({immediateHigh, immediateLow})
- `jumpTarget`  in  ADDR_WIDTH  absolute jump address (register file value)
- `memBEnabled`  out  1  read enable to instruction memory port B
- `memAddr`  out  ADDR_WIDTH  read address to port B
- `memData`  in  16  read data from port B, valid one cycle after enable
- `instruction`  out  16  instruction register, drives control unit
- `instrValid`  out  1  `instruction` holds the word at `pc`
- `pc`  out  ADDR_WIDTH  address of the current instruction
- `pcPlusOne`  out  ADDR_WIDTH  `pc + 1` mod 2^ADDR_WIDTH, link value for JAL

## Operation
- FSM states:
  - FETCH: `memBEnabled`=1, `memAddr`=`pc`; always goes to WAIT.
  - WAIT: memory is returning data; `memData` is captured into `instruction` at the end of the cycle; goes to HOLD.
  - HOLD: `instrValid`=1. Stays in HOLD until `pcEnabled`=1 is sampled. On that edge the PC updates and the FSM goes to FETCH.
- Next-PC priority in HOLD:
  1. `jumpEnable` → `jumpTarget`
  2. `branchMux` → `pc + sext(branchDisp)`
  3. neither → `pc + 1`
- All PC arithmetic is modulo 2^ADDR_WIDTH and wraps silently. `branchDisp` is sign-extended from bit 7 to ADDR_WIDTH.
- `pcEnabled`, `branchMux` and `jumpEnable` are ignored in FETCH and WAIT.
- `instruction` keeps its old value through FETCH and WAIT. It changes only at the WAIT→HOLD edge.
- `memAddr` equals `pc` in every state. `memBEnabled` is 0 outside FETCH.
- Reset values (`reset`=0 at a rising edge):
  - state = FETCH
  - `pc` = `memAddr` = RESET_PC
  - `pcPlusOne` = RESET_PC+1
  - `instruction` = 16'h0000
  - `instrValid` = 0
  - `memBEnabled` = 0 while `reset` is held low
- Reset mid-operation, in any state: same values as above. Any in-flight read is discarded and its data is never captured.

## Timing
- First fetch after reset release: FETCH in cycle 0, WAIT in cycle 1, `instrValid`=1 from cycle 2.
- Fetch latency is 2 cycles from entering FETCH to `instrValid`.
- `pcEnabled` sampled high in HOLD at edge N:
  - `pc` takes its new value in cycle N+1.
  - FETCH in cycle N+1, `instrValid`=0 in cycles N+1 and N+2, `instrValid`=1 from cycle N+3.
- Minimum issue interval is 3 cycles per instruction.
- `pcEnabled` held high continuously: the unit advances exactly once per HOLD visit, never twice per instruction.
- `pcPlusOne` is combinational from `pc`.

## Configuration
- `IFU_STALL_EN` defined:
  - Adds input port `stall` (1 bit).
  - While `stall`=1, FSM state, `pc` and `instruction` are frozen, and `memBEnabled` is forced to 0.
  - A stall during WAIT makes the unit re-enter FETCH at the same `pc` after the stall releases, so stale memory data is never captured.
  - `pcEnabled` sampled during a stall is ignored.
  - `reset` overrides `stall`.
- `IFU_STALL_EN` undefined: no `stall` port; behaviour is exactly as above.

## Test plan
- Reset release with `RESET_PC`=0, mem[0]=16'h0052:
  - `memBEnabled`=1 and `memAddr`=0 in cycle 0.
  - `instruction`=16'h0052 and `instrValid`=1 from cycle 2.
  - `pc`=0, `pcPlusOne`=1.
- HOLD with `pc`=0, pulse `pcEnabled`, mem[1]=16'h04c3:
  - `pc`=1 next cycle.
  - `instrValid` low for 2 cycles, then `instruction`=16'h04c3.
- Branch:
  - `pc`=16'h0005, `branchMux`=1, `branchDisp`=8'hFB (−5), `pcEnabled`=1 → `pc`=16'h0000.
  - `pc`=16'hFFFF, no branch → `pc`=16'h0000 (wrap).
- `jumpEnable`=1, `branchMux`=1, `jumpTarget`=16'h5a3f, `pcEnabled`=1 → `pc`=16'h5a3f; the jump wins.
- `reset`=0 during WAIT, fetching `pc`=3 → next cycle `pc`=0, `instruction`=0, `instrValid`=0; mem[3] data is never captured.
- `IFU_STALL_EN` defined, `stall`=1 for 4 cycles entered during WAIT at `pc`=2 → `memBEnabled`=0 throughout the stall; after release, FETCH at address 2 is reissued and mem[2] is captured.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, fetches 16-bit words from port-B BRAM into the instruction register.
// Ports:
//   clock, reset        system clock; synchronous active-low reset
//   pcEnabled           advance request from the control unit (honoured only in HOLD)
//   branchMux           next PC = pc + sext(branchDisp)
//   jumpEnable          next PC = jumpTarget (wins over branchMux)
//   branchDisp          signed 8-bit branch displacement
//   jumpTarget          absolute register-indirect jump address
//   memBEnabled/memAddr port-B read enable and address; memData returns one cycle later
//   instruction         instruction register feeding the control unit
//   instrValid          instruction holds the word at pc
//   pc, pcPlusOne       current instruction address and its link value
// Optional feature: define IFU_STALL_EN to add a stall input that freezes the unit.
module instruction_fetch_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clock,
  input  logic                  reset,
`ifdef IFU_STALL_EN
  input  logic                  stall,
`endif
  input  logic                  pcEnabled,
  input  logic                  branchMux,
  input  logic                  jumpEnable,
  input  logic [7:0]            branchDisp,
  input  logic [ADDR_WIDTH-1:0] jumpTarget,
  output logic                  memBEnabled,
  output logic [ADDR_WIDTH-1:0] memAddr,
  input  logic [15:0]           memData,
  output logic [15:0]           instruction,
  output logic                  instrValid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pcPlusOne
);
  typedef enum logic [1:0] {FETCH, WAIT, HOLD} stateT;
  stateT state;
  logic stallActive;
  logic [ADDR_WIDTH-1:0] nextPc;
`ifdef IFU_STALL_EN
  assign stallActive = stall;
`else
  assign stallActive = 1'b0;
`endif
  assign pcPlusOne   = pc + ADDR_WIDTH'(1);
  assign nextPc      = jumpEnable ? jumpTarget :
                       branchMux  ? pc + {{(ADDR_WIDTH-8){branchDisp[7]}}, branchDisp} : pcPlusOne;
  assign memAddr     = pc;
  assign memBEnabled = reset && !stallActive && state == FETCH;
  assign instrValid  = state == HOLD;
  always_ff @(posedge clock)
    if (!reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instruction <= '0;
    end else if (stallActive) begin
      // a stall in WAIT means the returning data may be stale, so the read is reissued
      if (state == WAIT) state <= FETCH;
    end else begin
      state <= state == FETCH ? WAIT : state == WAIT ? HOLD : pcEnabled ? FETCH : HOLD;
      if (state == WAIT) instruction <= memData;
      if (state == HOLD && pcEnabled) pc <= nextPc;
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized self-checking bench with a BRAM model and a next-PC reference model.
module tb_instruction_fetch_unit;
  logic clock = 0, reset = 0, pcEnabled = 0, branchMux = 0, jumpEnable = 0;
  logic [7:0] branchDisp = 0;
  logic [15:0] jumpTarget = 0, memAddr, memData = 0, instruction, pc, pcPlusOne;
  logic memBEnabled, instrValid;
`ifdef IFU_STALL_EN
  logic stall = 0;
`endif
  logic [15:0] mem [0:65535];
  logic [15:0] refPc;
  int checks = 0, fails = 0;

  instruction_fetch_unit dut (
    .clock(clock), .reset(reset),
`ifdef IFU_STALL_EN
    .stall(stall),
`endif
    .pcEnabled(pcEnabled), .branchMux(branchMux), .jumpEnable(jumpEnable),
    .branchDisp(branchDisp), .jumpTarget(jumpTarget), .memBEnabled(memBEnabled),
    .memAddr(memAddr), .memData(memData), .instruction(instruction),
    .instrValid(instrValid), .pc(pc), .pcPlusOne(pcPlusOne));

  initial forever #5 clock = ~clock;
  always @(posedge clock) if (memBEnabled) memData <= mem[memAddr];

  function automatic logic [15:0] refNext(logic [15:0] p, logic j, logic b, logic [7:0] d, logic [15:0] t);
    int s = int'($signed(d));
    if (j) return t;
    if (b) return 16'((int'(p) + s + 65536) % 65536);
    return 16'((int'(p) + 1) % 65536);
  endfunction

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic advance(input logic j, input logic b, input logic [7:0] d, input logic [15:0] t,
                         output logic [15:0] p1, output logic [2:0] v, output logic [15:0] ins,
                         output logic mbe, output logic [15:0] addr, output logic [15:0] p3);
    jumpEnable = j; branchMux = b; branchDisp = d; jumpTarget = t; pcEnabled = 1;
    step;
    p1 = pc; v[0] = instrValid; mbe = memBEnabled; addr = memAddr;
    jumpEnable = ~j; branchMux = ~b; jumpTarget = ~t;
    step;
    v[1] = instrValid;
    step;
    v[2] = instrValid; ins = instruction; p3 = pc;
    pcEnabled = 0; jumpEnable = 0; branchMux = 0;
  endtask

  task automatic runOne(input string name, input logic j, input logic b, input logic [7:0] d, input logic [15:0] t);
    logic [15:0] p1, ins, addr, p3, exp;
    logic [2:0] v;
    logic mbe;
    exp = refNext(refPc, j, b, d, t);
    advance(j, b, d, t, p1, v, ins, mbe, addr, p3);
    checks += 5;
    if (p1 !== exp) begin fails++; $display("FAIL %s pc: got %h want %h", name, p1, exp); end
    if (v !== 3'b100) begin fails++; $display("FAIL %s validSeq: got %b want 100", name, v); end
    if (ins !== mem[exp]) begin fails++; $display("FAIL %s instruction: got %h want %h", name, ins, mem[exp]); end
    if (mbe !== 1'b1 || addr !== exp) begin fails++; $display("FAIL %s fetch: got en=%b addr=%h want en=1 addr=%h", name, mbe, addr, exp); end
    if (p3 !== exp || pcPlusOne !== 16'(exp + 16'd1)) begin fails++; $display("FAIL %s hold: got pc=%h ppo=%h want %h", name, p3, pcPlusOne, exp); end
    refPc = exp;
  endtask

  task automatic test_reset;
    reset = 0;
    step; step;
    checks++;
    if (memBEnabled !== 0 || pc !== 0 || memAddr !== 0 || pcPlusOne !== 1 || instrValid !== 0 || instruction !== 0) begin
      fails++; $display("FAIL reset_held: got en=%b pc=%h addr=%h ppo=%h v=%b ins=%h want 0/0/0/1/0/0", memBEnabled, pc, memAddr, pcPlusOne, instrValid, instruction);
    end
    reset = 1;
    #1;
    checks++;
    if (memBEnabled !== 1 || memAddr !== 0 || instrValid !== 0) begin
      fails++; $display("FAIL reset_cycle0: got en=%b addr=%h v=%b want 1/0/0", memBEnabled, memAddr, instrValid);
    end
    step;
    checks++;
    if (memBEnabled !== 0 || instrValid !== 0 || instruction !== 0) begin
      fails++; $display("FAIL reset_cycle1: got en=%b v=%b ins=%h want 0/0/0", memBEnabled, instrValid, instruction);
    end
    step;
    checks++;
    if (instrValid !== 1 || instruction !== 16'h0052 || pc !== 0 || pcPlusOne !== 1) begin
      fails++; $display("FAIL reset_cycle2: got v=%b ins=%h pc=%h ppo=%h want 1/0052/0000/0001", instrValid, instruction, pc, pcPlusOne);
    end
    refPc = 0;
  endtask

  task automatic test_sequential;
    runOne("seq", 0, 0, 8'h00, 16'h0000);
    checks++;
    if (instruction !== 16'h04c3) begin fails++; $display("FAIL seq_word: got %h want 04c3", instruction); end
  endtask

  task automatic test_branch;
    runOne("jump5", 1, 0, 8'h00, 16'h0005);
    runOne("branch_neg5", 0, 1, 8'hFB, 16'h1234);
    checks++;
    if (pc !== 16'h0000) begin fails++; $display("FAIL branch_to_zero: got %h want 0000", pc); end
    runOne("jump_ffff", 1, 0, 8'h00, 16'hFFFF);
    runOne("wrap", 0, 0, 8'h10, 16'h1234);
    checks++;
    if (pc !== 16'h0000) begin fails++; $display("FAIL wrap_to_zero: got %h want 0000", pc); end
  endtask

  task automatic test_jump_priority;
    runOne("jump_prio", 1, 1, 8'($urandom), 16'h5a3f);
    checks++;
    if (pc !== 16'h5a3f) begin fails++; $display("FAIL jump_wins: got %h want 5a3f", pc); end
  endtask

  task automatic test_hold_idle;
    for (int i = 0; i < 6; i++) begin
      jumpEnable = 1'($urandom); branchMux = 1'($urandom);
      branchDisp = 8'($urandom); jumpTarget = 16'($urandom);
      step;
      checks++;
      if (pc !== refPc || instrValid !== 1 || memBEnabled !== 0 || instruction !== mem[refPc]) begin
        fails++; $display("FAIL hold_idle: got pc=%h v=%b en=%b ins=%h want pc=%h v=1 en=0 ins=%h", pc, instrValid, memBEnabled, instruction, refPc, mem[refPc]);
      end
    end
    jumpEnable = 0; branchMux = 0;
  endtask

  task automatic test_random;
    for (int i = 0; i < 25; i++)
      runOne("random", $urandom_range(0, 3) == 0, 1'($urandom), 8'($urandom), 16'($urandom));
  endtask

  task automatic test_reset_mid;
    jumpEnable = 1; jumpTarget = 16'h0003; pcEnabled = 1;
    step;
    pcEnabled = 0; jumpEnable = 0;
    step;
    checks++;
    if (pc !== 16'h0003 || instrValid !== 0) begin fails++; $display("FAIL mid_wait: got pc=%h v=%b want 0003/0", pc, instrValid); end
    reset = 0;
    step;
    checks++;
    if (pc !== 0 || instruction !== 0 || instrValid !== 0) begin
      fails++; $display("FAIL mid_reset: got pc=%h ins=%h v=%b want 0/0/0", pc, instruction, instrValid);
    end
    reset = 1;
    step; step;
    checks++;
    if (instrValid !== 1 || instruction !== mem[0] || pc !== 0) begin
      fails++; $display("FAIL mid_refetch: got v=%b ins=%h pc=%h want 1/%h/0 (mem3=%h)", instrValid, instruction, pc, mem[0], mem[3]);
    end
    refPc = 0;
  endtask

`ifdef IFU_STALL_EN
  task automatic test_stall;
    logic [15:0] fresh;
    jumpEnable = 1; jumpTarget = 16'h0002; pcEnabled = 1;
    step;
    pcEnabled = 0; jumpEnable = 0;
    step;
    fresh = mem[2] ^ 16'hA5A5;
    mem[2] = fresh;
    stall = 1; pcEnabled = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (memBEnabled !== 0 || pc !== 16'h0002 || instrValid !== 0) begin
        fails++; $display("FAIL stall_freeze: got en=%b pc=%h v=%b want 0/0002/0", memBEnabled, pc, instrValid);
      end
      if (i < 3) step;
    end
    stall = 0; pcEnabled = 0;
    #1;
    checks++;
    if (memBEnabled !== 1 || memAddr !== 16'h0002) begin
      fails++; $display("FAIL stall_refetch: got en=%b addr=%h want 1/0002", memBEnabled, memAddr);
    end
    step; step;
    checks++;
    if (instrValid !== 1 || instruction !== fresh || pc !== 16'h0002) begin
      fails++; $display("FAIL stall_capture: got v=%b ins=%h pc=%h want 1/%h/0002", instrValid, instruction, pc, fresh);
    end
    refPc = 16'h0002;
  endtask
`endif

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0052;
    mem[1] = 16'h04c3;
    mem[3] = 16'h0052 ^ 16'h1111;
    test_reset;
    test_sequential;
    test_branch;
    test_jump_priority;
    test_hold_idle;
    test_random;
    test_reset_mid;
`ifdef IFU_STALL_EN
    test_stall;
`endif
    test_hold_idle;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
